// File: rtl/instr_fetch.sv
// RV32I fetch stage: one outstanding word read, single-entry instruction buffer, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect latches misalign_err and halts fetching.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    HALT
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] redirect_target;
  logic        redirect_misaligned;
  logic        outstanding;

  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_target     = redirect_pc;
    redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    redirect_target     = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};
    redirect_misaligned = 1'b0;
`endif
    // A granted request whose response has not yet been seen this cycle.
    outstanding = ((state_reg == REQ) && imem_gnt) ||
                  (((state_reg == WAIT) || (state_reg == DRAIN)) && !imem_rvalid);
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_reg;
  assign misalign_err = misalign_reg;
`else
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_reg <= 1'b0;
`endif
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    else if (misalign_reg) begin
      // Halted: only finish draining a response that was already in flight.
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      if ((state_reg == DRAIN) && imem_rvalid) state_reg <= HALT;
    end
    else if (redirect_misaligned) begin
      misalign_reg <= 1'b1;
      pc_reg       <= redirect_target;
      imem_addr    <= redirect_target;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      state_reg    <= outstanding ? DRAIN : HALT;
    end
`endif
    else if (redirect_valid) begin
      pc_reg      <= redirect_target;
      imem_addr   <= redirect_target;
      instr_valid <= 1'b0;
      case (state_reg)
        REQ: begin
          if (imem_gnt) begin
            state_reg <= DRAIN;
            imem_req  <= 1'b0;
          end else begin
            state_reg <= REQ;
            imem_req  <= 1'b1;
          end
        end
        WAIT, DRAIN: begin
          if (imem_rvalid) begin
            state_reg <= REQ;
            imem_req  <= 1'b1;
          end else begin
            state_reg <= DRAIN;
            imem_req  <= 1'b0;
          end
        end
        default: begin
          state_reg <= REQ;
          imem_req  <= 1'b1;
        end
      endcase
    end
    else begin
      case (state_reg)
        IDLE: begin
          state_reg <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc_reg;
        end
        REQ: begin
          if (imem_gnt) begin
            state_reg <= WAIT;
            imem_req  <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc_reg;
            instr_valid <= 1'b1;
            pc_reg      <= pc_reg + 32'd4;
            imem_addr   <= pc_reg + 32'd4;
            state_reg   <= HOLD;
          end
        end
        HOLD: begin
          if (decode_ready) begin
            instr_valid <= 1'b0;
            state_reg   <= REQ;
            imem_req    <= 1'b1;
            imem_addr   <= pc_reg;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_reg <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_reg;
          end
        end
        default: begin
          state_reg <= IDLE;
          imem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
